// File: rtl/tour_move_stack.sv
// Move store for the knight's-tour solver: push/pop path building, start_tour on completion,
// and indexed playback reads for TourCmd.
//
// state | meaning
// IDLE  | waiting for go; push/pop ignored
// BUILD | solver extends/backtracks the path
// DONE  | tour complete; contents frozen, playback only
module tour_move_stack #(
    parameter int NUM_MOVES = 24,
    parameter int MV_W      = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_go,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [MV_W-1:0] i_move_in,
    input  logic [4:0]      i_mv_indx,
    output logic [MV_W-1:0] o_move,
    output logic [MV_W-1:0] o_top,
    output logic [4:0]      o_depth,
    output logic            o_empty,
    output logic            o_full,
    output logic            o_start_tour,
    output logic            o_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] LP_FULL = 5'(NUM_MOVES);

    state_t          r_state;
    logic [4:0]      r_depth;
    logic            r_err;
    logic            r_start;
    logic [MV_W-1:0] r_mem [NUM_MOVES];

    state_t          w_state_nxt;
    logic [4:0]      w_depth_nxt;
    logic            w_err_nxt;
    logic            w_start_nxt;
    logic            w_we;
    logic [4:0]      w_waddr;
    logic            w_onehot;
    logic [4:0]      w_top_idx;

    assign w_onehot  = (i_move_in != '0) &&
                       ((i_move_in & (i_move_in - {{(MV_W-1){1'b0}}, 1'b1})) == '0);
    assign w_top_idx = r_depth - 5'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_depth <= 5'd0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_depth <= w_depth_nxt;
            r_err   <= w_err_nxt;
            r_start <= w_start_nxt;
        end
    end

    // Storage is not reset: every read is gated by depth.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= i_move_in;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_depth_nxt = r_depth;
        w_err_nxt   = r_err;
        w_start_nxt = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_depth;

        if (i_go) begin
            w_state_nxt = BUILD;
            w_depth_nxt = 5'd0;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                BUILD: begin
                    if (i_push && !i_pop) begin
                        if (w_onehot && (r_depth < LP_FULL)) begin
                            w_we        = 1'b1;
                            w_depth_nxt = r_depth + 5'd1;
                            if (r_depth + 5'd1 == LP_FULL) begin
                                w_state_nxt = DONE;
                                w_start_nxt = 1'b1;
                            end
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else if (i_pop && !i_push) begin
                        if (r_depth != 5'd0) begin
                            w_depth_nxt = r_depth - 5'd1;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else if (i_push && i_pop) begin
                        // Simultaneous push/pop replaces the newest move in place.
                        if ((r_depth != 5'd0) && w_onehot) begin
                            w_we    = 1'b1;
                            w_waddr = w_top_idx;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (i_push || i_pop) begin
                        w_err_nxt = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_move       = (i_mv_indx < r_depth) ? r_mem[i_mv_indx] : '0;
    assign o_top        = (r_depth != 5'd0) ? r_mem[w_top_idx] : '0;
    assign o_depth      = r_depth;
    assign o_empty      = (r_depth == 5'd0);
    assign o_full       = (r_depth == LP_FULL);
    assign o_start_tour = r_start;
    assign o_err        = r_err;

endmodule

// File: tb/tb_tour_move_stack.sv
// Self-checking bench for tour_move_stack: directed table, hand sequences for
// completion/DONE/reset, and randomized traffic against a queue-based model.
module tb_tour_move_stack;

    logic       clk;
    logic       rst_n;
    logic       go, push, pop;
    logic [7:0] move_in;
    logic [4:0] mv_indx;
    logic [7:0] move, top;
    logic [4:0] depth;
    logic       empty, full, start_tour, err;

    int n_vec = 0;
    int n_err = 0;

    tour_move_stack #(.NUM_MOVES(24), .MV_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_push(push), .i_pop(pop),
        .i_move_in(move_in), .i_mv_indx(mv_indx), .o_move(move), .o_top(top),
        .o_depth(depth), .o_empty(empty), .o_full(full),
        .o_start_tour(start_tour), .o_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the path is a queue; mode 0=idle, 1=recording, 2=complete.
    logic [7:0] mq[$];
    int         m_mode;
    logic       m_err;
    logic       m_start;

    task automatic model_reset();
        mq.delete();
        m_mode  = 0;
        m_err   = 1'b0;
        m_start = 1'b0;
    endtask

    task automatic model_step(input logic g, input logic p, input logic o, input logic [7:0] mv);
        bit ok;
        ok = ($countones(mv) == 1);
        m_start = 1'b0;
        if (g) begin
            m_mode = 1;
            mq.delete();
            m_err = 1'b0;
        end else if (m_mode == 1) begin
            if (p && !o) begin
                if (ok && mq.size() < 24) begin
                    mq.push_back(mv);
                    if (mq.size() == 24) begin
                        m_mode  = 2;
                        m_start = 1'b1;
                    end
                end else m_err = 1'b1;
            end else if (o && !p) begin
                if (mq.size() > 0) void'(mq.pop_back());
                else m_err = 1'b1;
            end else if (p && o) begin
                if (mq.size() > 0 && ok) mq[mq.size()-1] = mv;
                else m_err = 1'b1;
            end
        end else if (m_mode == 2) begin
            if (p || o) m_err = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [7:0] e_move, e_top;
        e_move = (int'(mv_indx) < mq.size()) ? mq[mv_indx] : 8'h00;
        e_top  = (mq.size() > 0) ? mq[mq.size()-1] : 8'h00;
        chk("depth", 8'(depth), 8'(mq.size()));
        chk("top", top, e_top);
        chk("move", move, e_move);
        chk("empty", 8'(empty), 8'(mq.size() == 0));
        chk("full", 8'(full), 8'(mq.size() == 24));
        chk("start_tour", 8'(start_tour), 8'(m_start));
        chk("err", 8'(err), 8'(m_err));
    endtask

    task automatic step(input logic g, input logic p, input logic o,
                        input logic [7:0] mv, input logic [4:0] idx);
        go = g; push = p; pop = o; move_in = mv; mv_indx = idx;
        @(posedge clk);
        model_step(g, p, o, mv);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        go = 0; push = 0; pop = 0; move_in = 0; mv_indx = 0;
        #1;
        model_reset();
        check_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       g, p, o;
        logic [7:0] mv;
        logic [4:0] idx;
        logic [4:0] e_depth;
        logic [7:0] e_top;
        logic [7:0] e_move;
        logic       e_err;
    } vec_t;

    vec_t tbl[15];
    int   starts;

    initial begin
        tbl[0]  = '{1,0,0,8'h00,5'd0, 5'd0,8'h00,8'h00,0};
        tbl[1]  = '{0,1,0,8'h01,5'd0, 5'd1,8'h01,8'h01,0};
        tbl[2]  = '{0,1,0,8'h02,5'd1, 5'd2,8'h02,8'h02,0};
        tbl[3]  = '{0,1,0,8'h04,5'd2, 5'd3,8'h04,8'h04,0};
        tbl[4]  = '{0,0,1,8'h00,5'd2, 5'd2,8'h02,8'h00,0};
        tbl[5]  = '{0,0,1,8'h00,5'd1, 5'd1,8'h01,8'h00,0};
        tbl[6]  = '{0,0,1,8'h00,5'd0, 5'd0,8'h00,8'h00,0};
        tbl[7]  = '{0,0,1,8'h00,5'd0, 5'd0,8'h00,8'h00,1};
        tbl[8]  = '{0,1,0,8'h03,5'd0, 5'd0,8'h00,8'h00,1};
        tbl[9]  = '{1,0,0,8'h00,5'd0, 5'd0,8'h00,8'h00,0};
        tbl[10] = '{0,1,0,8'h10,5'd0, 5'd1,8'h10,8'h10,0};
        tbl[11] = '{0,1,0,8'h20,5'd1, 5'd2,8'h20,8'h20,0};
        tbl[12] = '{0,1,1,8'h80,5'd0, 5'd2,8'h80,8'h10,0};
        tbl[13] = '{0,1,1,8'h00,5'd0, 5'd2,8'h80,8'h10,1};
        tbl[14] = '{0,1,0,8'h00,5'd1, 5'd2,8'h80,8'h80,1};

        do_reset();

        // Full tour: 24 pushes, single start pulse, playback readback.
        step(1, 0, 0, 8'h00, 5'd0);
        starts = 0;
        for (int i = 0; i < 24; i++) begin
            step(0, 1, 0, 8'h01 << (i % 8), 5'(i));
            chk("seq1_depth", 8'(depth), 8'(i + 1));
            if (start_tour) starts++;
        end
        chk("seq1_full", 8'(full), 8'h01);
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 0, 8'h00, 5'(i));
            chk("seq1_move", move, 8'h01 << (i % 8));
            if (start_tour) starts++;
        end
        chk("seq1_start_count", 8'(starts), 8'h01);

        // DONE: push is an error, depth frozen, no second pulse; go restarts.
        step(0, 1, 0, 8'h01, 5'd23);
        chk("done_err", 8'(err), 8'h01);
        chk("done_depth", 8'(depth), 8'd24);
        chk("done_start", 8'(start_tour), 8'h00);
        step(1, 0, 0, 8'h00, 5'd0);
        chk("done_go_depth", 8'(depth), 8'h00);
        step(0, 1, 0, 8'h40, 5'd0);
        chk("done_go_build", 8'(depth), 8'h01);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].g, tbl[i].p, tbl[i].o, tbl[i].mv, tbl[i].idx);
            chk($sformatf("tbl%0d_depth", i), 8'(depth), 8'(tbl[i].e_depth));
            chk($sformatf("tbl%0d_top", i), top, tbl[i].e_top);
            chk($sformatf("tbl%0d_move", i), move, tbl[i].e_move);
            chk($sformatf("tbl%0d_err", i), 8'(err), 8'(tbl[i].e_err));
        end

        // Async reset mid-build at depth 10.
        step(1, 0, 0, 8'h00, 5'd0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h01 << (i % 8), 5'd0);
        chk("rst_pre_depth", 8'(depth), 8'd10);
        go = 0; push = 0; pop = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_depth", 8'(depth), 8'h00);
        chk("rst_move", move, 8'h00);
        chk("rst_start", 8'(start_tour), 8'h00);
        #1;
        rst_n = 1'b1;
        step(0, 1, 0, 8'h02, 5'd0);
        chk("rst_push_ignored", 8'(depth), 8'h00);
        step(1, 0, 0, 8'h00, 5'd0);
        step(0, 1, 0, 8'h02, 5'd0);
        chk("rst_go_push", 8'(depth), 8'h01);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic g, p, o;
            logic [7:0] mv;
            g  = ($urandom_range(0, 59) == 0);
            r  = int'($urandom_range(0, 99));
            p  = (r < 65) || (r >= 92);
            o  = (r >= 60);
            mv = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(8'h01 << $urandom_range(0, 7));
            step(g, p, o, mv, 5'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
